msfsm_fire_scheduler: RTL and testbench

Central scheduler for a set of synchronised multi-state FSMs, decomposed from one free-choice net, that share transitions.
- Computes which transitions are globally enabled: every participating FSM reports the transition enabled, and the environment requests it.
- Resolves free-choice conflicts by round-robin.
- Issues one one-hot fire strobe at a time and completes a 4-phase handshake with all participating FSMs.
- Sits beside the FSM bank, between the environment's transition requests and the FSM instances.

---
 rtl/msfsm_pkg.sv | 32 +++
 rtl/msfsm_rr_arbiter.sv | 29 ++
 rtl/msfsm_fire_scheduler.sv | 124 ++++++++++++
 tb/tb_msfsm_fire_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msfsm_pkg.sv
// Shared types and helpers for the multi-state-FSM fire scheduler.
package msfsm_pkg;

    localparam int DEF_NUM_T   = 7;
    localparam int DEF_NUM_FSM = 3;
    localparam logic [DEF_NUM_FSM*DEF_NUM_T-1:0] DEF_PART_MASK = 21'b1010111_1101011_1010111;

    // Upper bounds for the generic participant helper.
    localparam int MAX_FSM    = 16;
    localparam int MAX_MASK_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        FIRE,
        REL
    } state_t;

    // Bit f of the result is set when FSM f contains transition t.
    function automatic logic [MAX_FSM-1:0] participants(input logic [MAX_MASK_W-1:0] mask,
                                                        input int num_t,
                                                        input int num_fsm,
                                                        input int t);
        logic [MAX_FSM-1:0] p;
        p = '0;
        for (int f = 0; f < MAX_FSM; f++) begin
            if (f < num_fsm) p[f] = mask[8'(f * num_t + t)];
        end
        return p;
    endfunction

endpackage

// File: rtl/msfsm_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly above ptr, wrapping.
module msfsm_rr_arbiter #(
    parameter int NUM_T = 7
) (
    input  logic [NUM_T-1:0]         req,
    input  logic [$clog2(NUM_T)-1:0] ptr,
    output logic [NUM_T-1:0]         grant,
    output logic [$clog2(NUM_T)-1:0] grant_idx
);
    localparam int IW = $clog2(NUM_T);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        int j;
        grant     = '0;
        grant_idx = '0;
        j         = 0;
        // Scan from the farthest position down so the nearest request wins.
        for (int i = NUM_T; i >= 1; i--) begin
            j = (int'(ptr) + i) % NUM_T;
            if (req[IW'(j)]) begin
                grant            = '0;
                grant[IW'(j)]    = 1'b1;
                grant_idx        = IW'(j);
            end
        end
    end

endmodule

// File: rtl/msfsm_fire_scheduler.sv
// Central scheduler: computes global enables, arbitrates round-robin and runs a
// 4-phase fire/ack handshake with the participating component FSMs.
module msfsm_fire_scheduler
    import msfsm_pkg::*;
#(
    parameter int                         NUM_T           = DEF_NUM_T,
    parameter int                         NUM_FSM         = DEF_NUM_FSM,
    parameter logic [NUM_FSM*NUM_T-1:0]   PART_MASK       = DEF_PART_MASK,
    parameter int                         DEADLOCK_CYCLES = 255,
    parameter int                         CNT_W           = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_T-1:0]           t_req,
    input  logic [NUM_FSM*NUM_T-1:0]   t_en,
    input  logic [NUM_FSM-1:0]         fsm_ack,
    output logic [NUM_T-1:0]           t_fire,
    output logic                       busy,
    output logic [$clog2(NUM_T)-1:0]   last_t,
    output logic [CNT_W-1:0]           fire_count,
    output logic                       deadlock,
    output logic                       err_ack
);
    localparam int IW = $clog2(NUM_T);
    localparam int DW = $clog2(DEADLOCK_CYCLES + 1);
    localparam logic [MAX_MASK_W-1:0] MASK_EXT = MAX_MASK_W'(PART_MASK);

    state_t             state, next_state;
    logic [NUM_FSM-1:0] part_tbl [NUM_T];
    logic [NUM_T-1:0]   glob_en, cand, arb_grant;
    logic [IW-1:0]      arb_idx, rr_ptr, gidx_q;
    logic [NUM_FSM-1:0] part_q;
    logic [DW-1:0]      dl_cnt;
    logic               hs_done, hs_clear;

    // A transition is enabled when every participant enables it and it has at least one participant.
    always_comb begin
        logic [MAX_FSM-1:0] p;
        logic               all_en;
        p       = '0;
        all_en  = 1'b0;
        glob_en = '0;
        for (int t = 0; t < NUM_T; t++) begin
            p           = participants(MASK_EXT, NUM_T, NUM_FSM, t);
            part_tbl[t] = p[NUM_FSM-1:0];
            all_en      = 1'b1;
            for (int f = 0; f < NUM_FSM; f++) begin
                if (p[f] && !t_en[f*NUM_T+t]) all_en = 1'b0;
            end
            glob_en[t] = all_en && (p != '0);
        end
    end

    assign cand     = glob_en & t_req;
    assign hs_done  = (fsm_ack & part_q) == part_q;
    assign hs_clear = (fsm_ack & part_q) == '0;

    msfsm_rr_arbiter #(.NUM_T(NUM_T)) u_arb (
        .req       (cand),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ARB;
            ARB:     if (!start) next_state = IDLE;
                     else if (cand != '0) next_state = FIRE;
            FIRE:    if (hs_done) next_state = REL;
            REL:     if (hs_clear) next_state = start ? ARB : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    // NOTE: every register here is reset, including the latched grant, so nothing leaks X after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_fire     <= '0;
            part_q     <= '0;
            gidx_q     <= '0;
            rr_ptr     <= IW'(NUM_T - 1);
            last_t     <= '0;
            fire_count <= '0;
            deadlock   <= 1'b0;
            err_ack    <= 1'b0;
            dl_cnt     <= '0;
        end else begin
            if (state == ARB && next_state == FIRE) begin
                t_fire <= arb_grant;
                part_q <= part_tbl[arb_idx];
                gidx_q <= arb_idx;
            end
            if (state == FIRE && next_state == REL) begin
                t_fire <= '0;
                last_t <= gidx_q;
                rr_ptr <= gidx_q;
                if (fire_count != '1) fire_count <= fire_count + 1'b1;
            end
            if ((state == FIRE || state == REL) && ((fsm_ack & ~part_q) != '0)) err_ack <= 1'b1;
            // Starvation counter only runs while waiting in ARB with nothing enabled.
            if (state == ARB && next_state == ARB && glob_en == '0) begin
                if (dl_cnt != '1) dl_cnt <= dl_cnt + 1'b1;
                if (dl_cnt == DW'(DEADLOCK_CYCLES - 1)) deadlock <= 1'b1;
            end else begin
                dl_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_msfsm_fire_scheduler.sv
// Directed self-checking bench for msfsm_fire_scheduler.
module tb_msfsm_fire_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  t_req = '0;
    logic [20:0] t_en = '0;
    logic [2:0]  fsm_ack = '0;
    logic [6:0]  t_fire;
    logic        busy;
    logic [2:0]  last_t;
    logic [15:0] fire_count;
    logic        deadlock;
    logic        err_ack;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    msfsm_fire_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .t_req      (t_req),
        .t_en       (t_en),
        .fsm_ack    (fsm_ack),
        .t_fire     (t_fire),
        .busy       (busy),
        .last_t     (last_t),
        .fire_count (fire_count),
        .deadlock   (deadlock),
        .err_ack    (err_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        t_req   = '0;
        t_en    = '0;
        fsm_ack = '0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_fire(output logic [6:0] got, output bit timed_out);
        timed_out = 1'b1;
        got       = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (t_fire !== 7'b0) begin
                got       = t_fire;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        start   = 1'b1;
        t_req   = 7'($urandom);
        t_en    = 21'($urandom);
        fsm_ack = 3'($urandom);
        reset   = 1'b1;
        #2;
        tests_run++; if (t_fire !== 7'b0) begin tests_failed++; $display("FAIL reset_t_fire: got %b want 0", t_fire); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (fire_count !== 16'd0) begin tests_failed++; $display("FAIL reset_fire_count: got %0d want 0", fire_count); end
        tests_run++; if (deadlock !== 1'b0) begin tests_failed++; $display("FAIL reset_deadlock: got %b want 0", deadlock); end
        tests_run++; if (err_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_err_ack: got %b want 0", err_ack); end
        tests_run++; if (last_t !== 3'd0) begin tests_failed++; $display("FAIL reset_last_t: got %0d want 0", last_t); end
        tick();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_held_busy: got %b want 0", busy); end
        do_reset();
    endtask

    task automatic test_single_t3();
        do_reset();
        t_req = 7'b0001000;
        t_en  = 21'd1 << 10;
        start = 1'b1;
        tick();
        tests_run++; if (t_fire !== 7'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL t3_arb: got fire=%b busy=%b want fire=0 busy=1", t_fire, busy); end
        tick();
        tests_run++; if (t_fire !== 7'b0001000) begin tests_failed++; $display("FAIL t3_fire: got %b want 0001000", t_fire); end
        t_req = '0;
        t_en  = '0;
        tick();
        tests_run++; if (t_fire !== 7'b0001000) begin tests_failed++; $display("FAIL t3_hold: got %b want 0001000", t_fire); end
        fsm_ack = 3'b010;
        tick();
        tests_run++; if (t_fire !== 7'b0) begin tests_failed++; $display("FAIL t3_drop: got %b want 0", t_fire); end
        fsm_ack = 3'b000;
        start   = 1'b0;
        tick();
        tests_run++; if (fire_count !== 16'd1) begin tests_failed++; $display("FAIL t3_count: got %0d want 1", fire_count); end
        tests_run++; if (last_t !== 3'd3) begin tests_failed++; $display("FAIL t3_last_t: got %0d want 3", last_t); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL t3_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_free_choice();
        logic [6:0] exp_seq [4];
        logic [6:0] got;
        bit         to;
        exp_seq[0] = 7'b0000001;
        exp_seq[1] = 7'b0000010;
        exp_seq[2] = 7'b0000001;
        exp_seq[3] = 7'b0000010;
        do_reset();
        t_req = 7'b0000011;
        t_en  = '1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_fire(got, to);
            tests_run++;
            if (to || got !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got %b (timeout=%0d) want %b", i, got, to, exp_seq[i]);
            end
            fsm_ack = 3'b111;
            tick();
            fsm_ack = 3'b000;
            tick();
        end
        start = 1'b0;
        tick();
        tests_run++; if (fire_count !== 16'd4) begin tests_failed++; $display("FAIL rr_count: got %0d want 4", fire_count); end
        tests_run++; if (last_t !== 3'd1) begin tests_failed++; $display("FAIL rr_last_t: got %0d want 1", last_t); end
    endtask

    task automatic test_partial_enable();
        logic [6:0] got;
        bit         to;
        bit         seen;
        do_reset();
        t_req = 7'b0000100;
        t_en  = 21'd1 << 2;
        start = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            tick();
            if (t_fire !== 7'b0) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL partial_no_fire: got fired=%b want 0", seen); end
        t_en = (21'd1 << 2) | (21'd1 << 16);
        wait_fire(got, to);
        tests_run++; if (to || got !== 7'b0000100) begin tests_failed++; $display("FAIL partial_fire: got %b (timeout=%0d) want 0000100", got, to); end
        fsm_ack = 3'b001;
        tick();
        tick();
        tests_run++; if (t_fire !== 7'b0000100) begin tests_failed++; $display("FAIL partial_half_ack: got %b want 0000100", t_fire); end
        fsm_ack = 3'b101;
        tick();
        tests_run++; if (t_fire !== 7'b0) begin tests_failed++; $display("FAIL partial_full_ack: got %b want 0", t_fire); end
        tests_run++; if (err_ack !== 1'b0) begin tests_failed++; $display("FAIL partial_err_ack: got %b want 0", err_ack); end
        fsm_ack = 3'b000;
        start   = 1'b0;
        tick();
        tests_run++; if (fire_count !== 16'd1 || last_t !== 3'd2) begin tests_failed++; $display("FAIL partial_done: got count=%0d last=%0d want 1 2", fire_count, last_t); end
    endtask

    task automatic test_deadlock();
        logic [6:0] got;
        bit         to;
        do_reset();
        start = 1'b1;
        tick();
        repeat (254) tick();
        tests_run++; if (deadlock !== 1'b0) begin tests_failed++; $display("FAIL dl_early: got %b want 0 after 254 ARB cycles", deadlock); end
        tick();
        tests_run++; if (deadlock !== 1'b1) begin tests_failed++; $display("FAIL dl_set: got %b want 1 after 255 ARB cycles", deadlock); end
        t_req = 7'b0100000;
        t_en  = 21'd1 << 12;
        wait_fire(got, to);
        tests_run++; if (to || got !== 7'b0100000) begin tests_failed++; $display("FAIL dl_recover_fire: got %b (timeout=%0d) want 0100000", got, to); end
        fsm_ack = 3'b010;
        tick();
        fsm_ack = 3'b000;
        start   = 1'b0;
        tick();
        tests_run++; if (deadlock !== 1'b1) begin tests_failed++; $display("FAIL dl_sticky: got %b want 1", deadlock); end
        tests_run++; if (fire_count !== 16'd1 || last_t !== 3'd5) begin tests_failed++; $display("FAIL dl_done: got count=%0d last=%0d want 1 5", fire_count, last_t); end
    endtask

    task automatic test_ack_error();
        logic [6:0] got;
        bit         to;
        do_reset();
        t_req = 7'b0001000;
        t_en  = 21'd1 << 10;
        start = 1'b1;
        wait_fire(got, to);
        tests_run++; if (to || got !== 7'b0001000) begin tests_failed++; $display("FAIL err_fire: got %b (timeout=%0d) want 0001000", got, to); end
        fsm_ack = 3'b011;
        tick();
        tests_run++; if (err_ack !== 1'b1) begin tests_failed++; $display("FAIL err_set: got %b want 1", err_ack); end
        tests_run++; if (t_fire !== 7'b0) begin tests_failed++; $display("FAIL err_hs_done: got %b want 0", t_fire); end
        fsm_ack = 3'b000;
        start   = 1'b0;
        tick();
        tests_run++; if (fire_count !== 16'd1 || busy !== 1'b0) begin tests_failed++; $display("FAIL err_complete: got count=%0d busy=%b want 1 0", fire_count, busy); end
        tests_run++; if (err_ack !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b want 1", err_ack); end
    endtask

    task automatic test_reset_mid_fire();
        logic [6:0] got;
        bit         to;
        do_reset();
        t_req = 7'b0001000;
        t_en  = 21'd1 << 10;
        start = 1'b1;
        wait_fire(got, to);
        tests_run++; if (to || got !== 7'b0001000) begin tests_failed++; $display("FAIL midrst_fire: got %b (timeout=%0d) want 0001000", got, to); end
        reset = 1'b1;
        #1;
        tests_run++; if (t_fire !== 7'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_drop: got fire=%b busy=%b want 0 0", t_fire, busy); end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_t3();
        test_free_choice();
        test_partial_enable();
        test_deadlock();
        test_ack_error();
        test_reset_mid_fire();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
